tt_uio_bank: RTL and testbench
==============================

// Module: tt_uio_bank
// PURPOSE
//  Parametrised, register-mapped bidirectional IO bank for Tiny Tapeout user projects.
//  Generalises fixed 8-bit uio wiring: WIDTH pins, per-pin direction, synchronised inputs,
//  sticky rising-edge capture, interrupt masking and atomic output toggle.
//  Sits inside tt_um_* tops, driving uio_out/uio_oe from uio_in under a simple command port.
// PARAMETERS
//  WIDTH        8  number of IO pins (1..32)
//  SYNC_STAGES  2  input synchroniser depth (>=2)
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  ena        in   1      design enable; low freezes command port and edge capture
//  cmd_valid  in   1      command request
//  cmd_ready  out  1      bank can accept command
//  cmd_we     in   1      1 = write, 0 = read
//  cmd_addr   in   3      register address
//  cmd_wdata  in   WIDTH  write data
//  rsp_valid  out  1      one-cycle pulse: command completed
//  rsp_rdata  out  WIDTH  read data (0 for writes), valid with rsp_valid
//  pin_in     in   WIDTH  raw pad inputs (uio_in)
//  pin_out    out  WIDTH  pad output values (uio_out)
//  pin_oe     out  WIDTH  pad output enables, 1 = drive (uio_oe)
//  irq        out  1      |(EDGE & IEN), registered
// BEHAVIOUR
//  Reset: all registers, pin_out, pin_oe, rsp_valid, rsp_rdata, irq = 0; FSM = IDLE; syncs = 0.
//  Register map: 0 DIR (rw), 1 OUT (rw), 2 IN (ro, synced pins), 3 EDGE (read; write-1-to-clear),
//   4 IEN (rw), 5 TOGGLE (write: OUT ^= wdata; reads 0), 6-7 reserved (read 0, writes ignored).
//  pin_oe = DIR; pin_out = OUT (driven regardless of DIR).
//  FSM IDLE/RESP: cmd_ready = ena && state==IDLE. Accept on cmd_valid&&cmd_ready -> RESP.
//   RESP: rsp_valid=1 for exactly that cycle, return to IDLE. Accept-to-response latency 1 cycle;
//   max throughput 1 command / 2 cycles; no response backpressure.
//  Write effect visible on pin_out/pin_oe the cycle after accept (same cycle as rsp_valid).
//  Read data = register value in the accept cycle, registered into rsp_rdata.
//  Synchroniser: pin_in change appears in IN after SYNC_STAGES cycles.
//  Edge: EDGE[i] set when IN[i] rises 0->1 and DIR[i]==0; output pins never set EDGE.
//   Same-cycle set and W1C clear on one bit: set wins (bit stays 1).
//  irq updates one cycle after EDGE/IEN change.
//  ena low: cmd_ready=0, FSM finishes any pending RESP, EDGE frozen, synchronisers keep running.
//  Reset mid-command: pending response discarded, no rsp_valid after reset release.
//  Unused high bits of cmd_wdata ignored when WIDTH<32 not applicable (port is WIDTH wide).
// STRUCTURE
//  Package tt_uio_pkg: address constants (ADDR_DIR..ADDR_TOGGLE), FSM state enum, ADDR_W=3.
//  Sub-module tt_sync_bit (SYNC_STAGES flops, async reset to 0), instantiated WIDTH times.
//  Register file, edge logic, FSM and read mux live in tt_uio_bank.
// TESTING
//  Reset: hold rst_n=0 with pin_in=8'hFF -> pin_oe=0, pin_out=0, irq=0, cmd_ready=0 until ena=1.
//  Write DIR=8'h0F, OUT=8'hA5 -> next cycle pin_oe=8'h0F, pin_out=8'hA5; read back 8'h0F/8'hA5.
//  TOGGLE write 8'hFF with OUT=8'hA5 -> pin_out=8'h5A; read TOGGLE -> rsp_rdata=0.
//  DIR=8'h0F, IEN=8'hF0, pin_in 0->8'hFF -> IN=8'hFF after 2 cycles, EDGE=8'hF0, irq=1.
//  W1C EDGE=8'h10 in same cycle pin 4 re-rises -> EDGE[4] stays 1; clear without edge -> irq=0.
//  Back-to-back cmd_valid held high -> cmd_ready low in RESP, one rsp_valid per accepted command;
//   rst_n pulse during RESP -> no rsp_valid, registers return to 0.

Source files
------------

// File: rtl/tt_uio_pkg.sv
// Shared constants for the tt_uio_bank register-mapped IO bank:
// register addresses and the command-port state encoding.
package tt_uio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DIR    = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_OUT    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IN     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_IEN    = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_TOGGLE = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/tt_sync_bit.sv
// Single-bit multi-flop synchroniser for one raw pad input.
module tt_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/tt_uio_bank.sv
// Register-mapped bidirectional IO bank: direction/output registers, synchronised
// inputs, sticky rising-edge capture with interrupt mask, and atomic output toggle.
module tt_uio_bank
    import tt_uio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [WIDTH-1:0]  cmd_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    input  logic [WIDTH-1:0]  pin_in,
    output logic [WIDTH-1:0]  pin_out,
    output logic [WIDTH-1:0]  pin_oe,
    output logic              irq
);

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_dir;
    logic [WIDTH-1:0]  r_out;
    logic [WIDTH-1:0]  r_in_prev;
    logic [WIDTH-1:0]  r_edge;
    logic [WIDTH-1:0]  r_ien;
    logic [WIDTH-1:0]  r_rdata;
    logic              r_irq;
    logic [WIDTH-1:0]  w_in;
    logic [WIDTH-1:0]  w_rise;
    logic [WIDTH-1:0]  w_clr;
    logic [WIDTH-1:0]  w_rdata;
    logic              w_accept;
    logic              w_wr;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
            tt_sync_bit #(
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (pin_in[gi]),
                .q     (w_in[gi])
            );
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = ena;
                if (cmd_valid && ena) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_accept = cmd_valid && cmd_ready;
    assign w_wr     = w_accept && cmd_we;

    // Only input pins can record edges; W1C clear is applied before the set so a
    // coincident rise keeps the bit.
    assign w_rise = w_in & ~r_in_prev & ~r_dir;
    assign w_clr  = (w_wr && cmd_addr == ADDR_EDGE) ? cmd_wdata : '0;

    always_comb begin
        w_rdata = '0;
        case (cmd_addr)
            ADDR_DIR:  w_rdata = r_dir;
            ADDR_OUT:  w_rdata = r_out;
            ADDR_IN:   w_rdata = w_in;
            ADDR_EDGE: w_rdata = r_edge;
            ADDR_IEN:  w_rdata = r_ien;
            default:   w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_dir     <= '0;
            r_out     <= '0;
            r_in_prev <= '0;
            r_edge    <= '0;
            r_ien     <= '0;
            r_rdata   <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_in_prev <= w_in;
            r_irq     <= |(r_edge & r_ien);
            if (ena) begin
                r_edge <= (r_edge & ~w_clr) | w_rise;
            end
            if (w_accept) begin
                r_rdata <= cmd_we ? '0 : w_rdata;
            end
            if (w_wr) begin
                case (cmd_addr)
                    ADDR_DIR:    r_dir <= cmd_wdata;
                    ADDR_OUT:    r_out <= cmd_wdata;
                    ADDR_IEN:    r_ien <= cmd_wdata;
                    ADDR_TOGGLE: r_out <= r_out ^ cmd_wdata;
                    default:     ;
                endcase
            end
        end
    end

    assign pin_oe    = r_dir;
    assign pin_out   = r_out;
    assign rsp_rdata = r_rdata;
    assign irq       = r_irq;

endmodule

// File: tb/tb_tt_uio_bank.sv
// Directed self-checking bench for tt_uio_bank (WIDTH=8, SYNC_STAGES=2).
module tb_tt_uio_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [7:0] pin_in;
    logic [7:0] pin_out;
    logic [7:0] pin_oe;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tt_uio_bank #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .pin_in    (pin_in),
        .pin_out   (pin_out),
        .pin_oe    (pin_oe),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge of the response cycle.
    task automatic do_cmd(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd);
        int waits;
        waits     = 0;
        rd        = 8'h00;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wd;
        while (!cmd_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            rd = rsp_rdata;
            if (we) check("wr_rdata_zero", {24'd0, rsp_rdata}, 32'd0);
            $display("cmd we=%0d addr=%0d wdata=%02h rdata=%02h", we, addr, wd, rd);
        end
    endtask

    initial begin
        logic [7:0] rd;
        int         rsp_cnt;

        rst_n     = 1'b0;
        ena       = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 3'd0;
        cmd_wdata = 8'h00;
        pin_in    = 8'hFF;

        repeat (3) @(negedge clk);
        check("rst_pin_oe",    {24'd0, pin_oe}, 32'd0);
        check("rst_pin_out",   {24'd0, pin_out}, 32'd0);
        check("rst_irq",       {31'd0, irq}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        pin_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("ena_low_ready", {31'd0, cmd_ready}, 32'd0);
        ena = 1'b1;
        #1;
        check("ena_high_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);

        // Direction and output registers
        do_cmd(1'b1, 3'd0, 8'h0F, rd);
        check("pin_oe_after_wr", {24'd0, pin_oe}, 32'h0F);
        do_cmd(1'b1, 3'd1, 8'hA5, rd);
        check("pin_out_after_wr", {24'd0, pin_out}, 32'hA5);
        do_cmd(1'b0, 3'd0, 8'h00, rd);
        check("rd_dir", {24'd0, rd}, 32'h0F);
        do_cmd(1'b0, 3'd1, 8'h00, rd);
        check("rd_out", {24'd0, rd}, 32'hA5);

        // Toggle
        do_cmd(1'b1, 3'd5, 8'hFF, rd);
        check("pin_out_toggle", {24'd0, pin_out}, 32'h5A);
        do_cmd(1'b0, 3'd5, 8'h00, rd);
        check("rd_toggle_zero", {24'd0, rd}, 32'h00);

        // Reserved address
        do_cmd(1'b1, 3'd6, 8'hFF, rd);
        do_cmd(1'b0, 3'd6, 8'h00, rd);
        check("rd_reserved", {24'd0, rd}, 32'h00);
        do_cmd(1'b0, 3'd0, 8'h00, rd);
        check("rd_dir_untouched", {24'd0, rd}, 32'h0F);

        // Edge capture and interrupt
        do_cmd(1'b1, 3'd4, 8'hF0, rd);
        check("irq_before_edge", {31'd0, irq}, 32'd0);
        @(negedge clk);
        pin_in = 8'hFF;
        repeat (2) @(negedge clk);
        do_cmd(1'b0, 3'd2, 8'h00, rd);
        check("rd_in", {24'd0, rd}, 32'hFF);
        do_cmd(1'b0, 3'd3, 8'h00, rd);
        check("rd_edge", {24'd0, rd}, 32'hF0);
        check("irq_set", {31'd0, irq}, 32'd1);

        // W1C coinciding with a fresh rise on pin 4: set must win
        @(negedge clk);
        pin_in = 8'hEF;
        repeat (4) @(negedge clk);
        pin_in = 8'hFF;
        repeat (2) @(negedge clk);
        do_cmd(1'b1, 3'd3, 8'h10, rd);
        do_cmd(1'b0, 3'd3, 8'h00, rd);
        check("edge_set_wins", {24'd0, rd}, 32'hF0);

        // Plain clear, irq drops one cycle later
        do_cmd(1'b1, 3'd3, 8'hFF, rd);
        @(negedge clk);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        do_cmd(1'b0, 3'd3, 8'h00, rd);
        check("edge_cleared", {24'd0, rd}, 32'h00);

        // Back-to-back: cmd_valid held high
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 3'd0;
        rsp_cnt   = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
            check($sformatf("b2b_rsp_%0d", k), {31'd0, rsp_valid}, (k % 2));
            check($sformatf("b2b_ready_%0d", k), {31'd0, cmd_ready}, 1 - (k % 2));
        end
        check("b2b_rsp_count", rsp_cnt, 3);

        // Reset asserted while a response is pending
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_rsp", {31'd0, rsp_valid}, 32'd1);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_oe",  {24'd0, pin_oe}, 32'd0);
        check("mid_rst_out", {24'd0, pin_out}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        rsp_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
        end
        check("post_rst_no_rsp", rsp_cnt, 0);
        do_cmd(1'b0, 3'd0, 8'h00, rd);
        check("post_rst_dir", {24'd0, rd}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
